axi_regs_responder: RTL and testbench

AXI3 slave (PS Master GP port flavour: 32-bit data, 12-bit IDs, 4-bit LEN) that answers register reads and writes from the PS into a local register file of `2**REG_AW` 32-bit words. It is the responder side of the GP1 transactions issued by the simulation masters. It sits between the GP1 port and the SATA host-controller register space. Read and write channels are independent, each with one outstanding burst.

---
 rtl/axi_regs_pkg.sv | 43 ++++
 rtl/axi_regs_responder_if.sv | 56 +++++
 rtl/axi_regs_file.sv | 37 +++
 rtl/axi_regs_responder.sv | 184 ++++++++++++++++++
 tb/tb_axi_regs_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/axi_regs_pkg.sv
// Shared types for the AXI3 GP register responder: response/burst codes,
// channel FSM states and the per-burst context latched at the address handshake.
package axi_regs_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 12;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  // Burst attributes captured on AW/AR acceptance
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic             fixed;
    logic             decerr;
  } burst_ctx_t;

endpackage

// File: rtl/axi_regs_responder_if.sv
// AXI3 GP-port bundle (32-bit data, 12-bit IDs, 4-bit LEN) between PS master and register responder.
interface axi_regs_responder_if;
  import axi_regs_pkg::*;

  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   ARID;
  logic [LEN_W-1:0]  ARLEN;
  logic [1:0]        ARSIZE;
  logic [1:0]        ARBURST;

  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic [ID_W-1:0]   RID;
  logic              RLAST;
  logic [1:0]        RRESP;

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [ID_W-1:0]   AWID;
  logic [LEN_W-1:0]  AWLEN;
  logic [1:0]        AWSIZE;
  logic [1:0]        AWBURST;

  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   WID;
  logic              WLAST;
  logic [STRB_W-1:0] WSTRB;

  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;

  modport master (
    output ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
           AWADDR, AWVALID, AWID, AWLEN, AWSIZE, AWBURST,
           WDATA, WVALID, WID, WLAST, WSTRB, BREADY,
    input  ARREADY, RDATA, RVALID, RID, RLAST, RRESP,
           AWREADY, WREADY, BVALID, BID, BRESP
  );

  modport slave (
    input  ARADDR, ARVALID, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
           AWADDR, AWVALID, AWID, AWLEN, AWSIZE, AWBURST,
           WDATA, WVALID, WID, WLAST, WSTRB, BREADY,
    output ARREADY, RDATA, RVALID, RID, RLAST, RRESP,
           AWREADY, WREADY, BVALID, BID, BRESP
  );

endinterface

// File: rtl/axi_regs_file.sv
// 2**AW x 32 register array: byte-enabled write port, registered read port.
// A read and a write to the same word in one cycle returns the old contents.
module axi_regs_file #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      // rclr serves out-of-range bursts, which read back as zero
      if (re) rdata <= rclr ? 32'h0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_regs_responder.sv
// AXI3 GP1 slave answering register reads/writes into a local 2**REG_AW-word file.
// Optional AXI_REGS_RESP_WID_CHECK_EN: WID mismatch drops the beat and returns SLVERR.
module axi_regs_responder
  import axi_regs_pkg::*;
#(
  parameter int unsigned REG_AW = 4,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_regs_responder_if.slave  bus
);

  localparam int unsigned TAG_LSB = REG_AW + 2;

  // ---------------- write channel ----------------
  w_state_e          w_state, w_state_nxt;
  burst_ctx_t        w_ctx;
  logic [REG_AW-1:0] w_addr;
  logic [LEN_W-1:0]  w_cnt;
  logic              w_slverr;
  logic              wlast_err;
  logic              awready, wready, bvalid;
  logic [1:0]        bresp;
  logic              aw_hs_c, w_beat_c, w_last_c, wid_bad_c, we_c;

  assign aw_hs_c  = bus.AWVALID & awready;
  assign w_beat_c = bus.WVALID & wready;
  assign w_last_c = (w_cnt == w_ctx.len);
  assign we_c     = w_beat_c & ~w_ctx.decerr & ~wid_bad_c;

`ifdef AXI_REGS_RESP_WID_CHECK_EN
  assign wid_bad_c = (bus.WID != w_ctx.id);
`else
  logic unused_wid;
  assign wid_bad_c  = 1'b0;
  assign unused_wid = ^bus.WID;
`endif

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs_c) w_state_nxt = W_DATA;
      W_DATA:  if (w_beat_c && w_last_c) w_state_nxt = W_RESP;
      W_RESP:  if (bus.BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ctx     <= '0;
      w_addr    <= '0;
      w_cnt     <= '0;
      w_slverr  <= 1'b0;
      wlast_err <= 1'b0;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      awready <= (w_state_nxt == W_IDLE);
      wready  <= (w_state_nxt == W_DATA);
      bvalid  <= (w_state_nxt == W_RESP);
      if (aw_hs_c) begin
        w_ctx    <= '{id:     bus.AWID,
                      len:    bus.AWLEN,
                      fixed:  (bus.AWBURST == BURST_FIXED),
                      decerr: (bus.AWADDR[31:TAG_LSB] != BASE[31:TAG_LSB])};
        w_addr   <= bus.AWADDR[REG_AW+1:2];
        w_cnt    <= '0;
        w_slverr <= 1'b0;
      end
      if (w_beat_c) begin
        w_cnt <= w_cnt + 1'b1;
        if (!w_ctx.fixed) w_addr <= w_addr + 1'b1;
        if (wid_bad_c) w_slverr <= 1'b1;
        // WLAST does not steer the FSM; a disagreement is only recorded
        if (bus.WLAST != w_last_c) wlast_err <= 1'b1;
        if (w_last_c) begin
          bresp <= w_ctx.decerr ? RESP_DECERR
                 : ((w_slverr | wid_bad_c) ? RESP_SLVERR : RESP_OKAY);
        end
      end
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = w_ctx.id;
  assign bus.BRESP   = bresp;

  // ---------------- read channel ----------------
  r_state_e          r_state, r_state_nxt;
  burst_ctx_t        r_ctx;
  logic [REG_AW-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              arready, rvalid, rlast;
  logic [1:0]        rresp;
  logic [31:0]       rdata;
  logic              ar_hs_c, rd_en_c, r_last_c;

  assign ar_hs_c  = bus.ARVALID & arready;
  assign r_last_c = (r_cnt == r_ctx.len);

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    rd_en_c     = 1'b0;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_nxt = R_FETCH;
      R_FETCH: begin
        rd_en_c     = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA:  if (bus.RREADY) r_state_nxt = r_last_c ? R_IDLE : R_FETCH;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctx   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
    end else begin
      arready <= (r_state_nxt == R_IDLE);
      rvalid  <= (r_state_nxt == R_DATA);
      if (ar_hs_c) begin
        r_ctx  <= '{id:     bus.ARID,
                    len:    bus.ARLEN,
                    fixed:  (bus.ARBURST == BURST_FIXED),
                    decerr: (bus.ARADDR[31:TAG_LSB] != BASE[31:TAG_LSB])};
        r_addr <= bus.ARADDR[REG_AW+1:2];
        r_cnt  <= '0;
        rresp  <= (bus.ARADDR[31:TAG_LSB] != BASE[31:TAG_LSB]) ? RESP_DECERR : RESP_OKAY;
      end
      if (rd_en_c) rlast <= r_last_c;
      if (r_state == R_DATA && bus.RREADY && !r_last_c) begin
        r_cnt <= r_cnt + 1'b1;
        if (!r_ctx.fixed) r_addr <= r_addr + 1'b1;
      end
    end
  end

  axi_regs_file #(.AW(REG_AW)) u_file (
    .clk   (clk),
    .reset (reset),
    .we    (we_c),
    .waddr (w_addr),
    .wdata (bus.WDATA),
    .wstrb (bus.WSTRB),
    .re    (rd_en_c),
    .rclr  (r_ctx.decerr),
    .raddr (r_addr),
    .rdata (rdata)
  );

  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RID     = r_ctx.id;
  assign bus.RLAST   = rlast;
  assign bus.RRESP   = rresp;

  // Size and byte-lane address bits carry no meaning for word registers
  logic unused_bits;
  assign unused_bits = ^{bus.ARSIZE, bus.AWSIZE, bus.ARADDR[1:0], bus.AWADDR[1:0], wlast_err};

endmodule

// File: tb/tb_axi_regs_responder.sv
// Directed bench for axi_regs_responder: register writes/reads, bursts with wrap,
// DECERR range, optional WID check and mid-burst reset.
module tb_axi_regs_responder;
  import axi_regs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wdat [16];
  logic [31:0] rexp [16];

  always #5 clk = ~clk;

  axi_regs_responder_if bus ();

  axi_regs_responder #(.REG_AW(4), .BASE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 32'(bus.ARREADY), 32'd1);
    check({tag, "_awready"}, 32'(bus.AWREADY), 32'd1);
    check({tag, "_wready"},  32'(bus.WREADY),  32'd0);
    check({tag, "_rvalid"},  32'(bus.RVALID),  32'd0);
    check({tag, "_bvalid"},  32'(bus.BVALID),  32'd0);
    check({tag, "_rdata"},   bus.RDATA,        32'h0);
    check({tag, "_rlast"},   32'(bus.RLAST),   32'd0);
    check({tag, "_rid"},     32'(bus.RID),     32'h0);
    check({tag, "_bid"},     32'(bus.BID),     32'h0);
    check({tag, "_rresp"},   32'(bus.RRESP),   32'd0);
    check({tag, "_bresp"},   32'(bus.BRESP),   32'd0);
  endtask

  // Called just after a negedge; beats come from wdat[]
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [11:0] id,
                          input logic [3:0] len, input logic [1:0] burst, input logic [3:0] strb,
                          input logic [11:0] wid, input logic [1:0] exp_resp);
    int n;
    bus.AWADDR = addr; bus.AWID = id; bus.AWLEN = len; bus.AWBURST = burst;
    bus.AWSIZE = 2'd2; bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    check({tag, "_aw_timeout"}, 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check({tag, "_wready_n1"}, 32'(bus.WREADY), 32'd1);
    check({tag, "_awready_busy"}, 32'(bus.AWREADY), 32'd0);
    for (int b = 0; b <= int'(len); b++) begin
      bus.WDATA = wdat[b]; bus.WSTRB = strb; bus.WID = wid;
      bus.WLAST = (b == int'(len)); bus.WVALID = 1'b1;
      n = 0;
      while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
      check({tag, "_w_timeout"}, 32'(n < 50), 32'd1);
      @(negedge clk);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check({tag, "_bvalid_m1"}, 32'(bus.BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(bus.BRESP), 32'(exp_resp));
    check({tag, "_bid"}, 32'(bus.BID), 32'(id));
    @(negedge clk);
    check({tag, "_bvalid_hold"}, 32'(bus.BVALID), 32'd1);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check({tag, "_bvalid_done"}, 32'(bus.BVALID), 32'd0);
    check({tag, "_awready_done"}, 32'(bus.AWREADY), 32'd1);
  endtask

  // Called just after a negedge; expected beats come from rexp[]
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [11:0] id,
                         input logic [3:0] len, input logic [1:0] burst, input logic [1:0] exp_resp);
    int n;
    bus.ARADDR = addr; bus.ARID = id; bus.ARLEN = len; bus.ARBURST = burst;
    bus.ARSIZE = 2'd2; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ar_timeout"}, 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    check({tag, "_rvalid_n1"}, 32'(bus.RVALID), 32'd0);
    check({tag, "_arready_busy"}, 32'(bus.ARREADY), 32'd0);
    @(negedge clk);
    check({tag, "_rvalid_n2"}, 32'(bus.RVALID), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
      check({tag, "_r_timeout"}, 32'(n < 50), 32'd1);
      check($sformatf("%s_rdata%0d", tag, b), bus.RDATA, rexp[b]);
      check($sformatf("%s_rid%0d", tag, b), 32'(bus.RID), 32'(id));
      check($sformatf("%s_rresp%0d", tag, b), 32'(bus.RRESP), 32'(exp_resp));
      check($sformatf("%s_rlast%0d", tag, b), 32'(bus.RLAST), 32'(b == int'(len)));
      if (b == 0) begin
        @(negedge clk);
        check({tag, "_rvalid_hold"}, 32'(bus.RVALID), 32'd1);
        check({tag, "_rdata_hold"}, bus.RDATA, rexp[0]);
      end
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
    check({tag, "_arready_done"}, 32'(bus.ARREADY), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARLEN = '0;
    bus.ARSIZE = 2'd2; bus.ARBURST = BURST_INCR; bus.RREADY = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWLEN = '0;
    bus.AWSIZE = 2'd2; bus.AWBURST = BURST_INCR;
    bus.WDATA = '0; bus.WVALID = 1'b0; bus.WID = '0; bus.WLAST = 1'b0; bus.WSTRB = '0;
    bus.BREADY = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Partial-strobe single write, then read back
    wdat[0] = 32'hdeadbeef;
    do_write("w1", 32'h5, 12'h0, 4'd0, BURST_INCR, 4'b1011, 12'h0, RESP_OKAY);
    rexp[0] = 32'hde00beef;
    do_read("r1", 32'h5, 12'h7, 4'd0, BURST_INCR, RESP_OKAY);

    // INCR write wrapping past word 15
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    do_write("w4", 32'h38, 12'h3a, 4'd3, BURST_INCR, 4'hf, 12'h3a, RESP_OKAY);
    rexp[0] = 32'd2; rexp[1] = 32'd2;
    do_read("rfix", 32'h3c, 12'h11, 4'd1, BURST_FIXED, RESP_OKAY);
    rexp[0] = 32'd1; rexp[1] = 32'd2; rexp[2] = 32'd3; rexp[3] = 32'd4;
    do_read("rinc", 32'h38, 12'h22, 4'd3, BURST_INCR, RESP_OKAY);
    rexp[0] = 32'd3; rexp[1] = 32'd4;
    do_read("rwrap", 32'h0, 12'h33, 4'd1, BURST_WRAP, RESP_OKAY);

    // Out of range: write dropped, read returns zero with DECERR
    wdat[0] = 32'hffffffff;
    do_write("wdec", 32'h1000, 12'h44, 4'd0, BURST_INCR, 4'hf, 12'h44, RESP_DECERR);
    rexp[0] = 32'd3;
    do_read("rafterdec", 32'h0, 12'h45, 4'd0, BURST_INCR, RESP_OKAY);
    rexp[0] = 32'h0;
    do_read("rdec", 32'h1000, 12'h46, 4'd0, BURST_INCR, RESP_DECERR);

    // WID mismatch on word 2
    wdat[0] = 32'h55;
`ifdef AXI_REGS_RESP_WID_CHECK_EN
    do_write("wwid", 32'h8, 12'h123, 4'd0, BURST_INCR, 4'hf, 12'h124, RESP_SLVERR);
    rexp[0] = 32'h0;
`else
    do_write("wwid", 32'h8, 12'h123, 4'd0, BURST_INCR, 4'hf, 12'h124, RESP_OKAY);
    rexp[0] = 32'h55;
`endif
    do_read("rwid", 32'h8, 12'h124, 4'd0, BURST_INCR, RESP_OKAY);

    // Reset in the middle of a stalled 4-beat read
    bus.ARADDR = 32'h38; bus.ARID = 12'h9; bus.ARLEN = 4'd3; bus.ARBURST = BURST_INCR;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
    check("midrst_timeout", 32'(n < 50), 32'd1);
    check("midrst_rid_pre", 32'(bus.RID), 32'h9);
    check("midrst_rdata_pre", bus.RDATA, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rexp[i] = 32'h0;
    do_read("rclr", 32'h0, 12'h5a, 4'd15, BURST_INCR, RESP_OKAY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
